glitch_filter_mc: RTL and testbench

Parametrised multi-channel glitch filter and debouncer. It is the successor to the single-channel 3-sample filter.
- Each channel's output changes only after DEPTH consecutive sample ticks disagree with the current output.
- Sampling is paced by a shared prescaler.
- Per-channel one-cycle rise and fall pulses are produced.
- Sits between raw pads or switch inputs and the synchronous control logic.

---
 rtl/glitch_filter_pkg.sv | 21 ++
 rtl/glitch_filter_chan.sv | 84 ++++++++
 rtl/glitch_filter_mc.sv | 59 +++++
 tb/tb_glitch_filter_mc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/glitch_filter_pkg.sv
// Shared constants and helpers for the multi-channel glitch filter.
// Optional input synchroniser is selected with GLITCH_FILTER_SYNC_EN.
package glitch_filter_pkg;

  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_DEPTH     = 3;
  localparam int DEF_PRESCALE  = 1;
  localparam bit DEF_RESET_VAL = 1'b0;

  // Minimum width of 1 so that depth/prescale values of 1 still get a real register.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  localparam int CNT_W  = clog2(DEF_DEPTH);
  localparam int PCNT_W = clog2(DEF_PRESCALE);

endpackage

// File: rtl/glitch_filter_chan.sv
// One filter channel: optional 2-flop synchroniser (GLITCH_FILTER_SYNC_EN),
// disagreement counter, filtered level and registered edge pulses.
module glitch_filter_chan
  import glitch_filter_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit RESET_VAL = DEF_RESET_VAL
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_i,
  input  logic sig_i,
  output logic sig_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_WIDTH = clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEPTH - 1);

  logic                 sample;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_q, out_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

`ifdef GLITCH_FILTER_SYNC_EN
  logic meta_q, sync_q;

  // Synchroniser runs every cycle so it keeps tracking the pad while sampling is disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
    end
  end

  assign sample = sync_q;
`else
  assign sample = sig_i;
`endif

  // Any agreeing tick throws away progress, so only an unbroken run can flip the output.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (tick_i) begin
      if (sample == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        out_d  = sample;
        rise_d = sample;
        fall_d = ~sample;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      out_q  <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sig_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/glitch_filter_mc.sv
// Multi-channel glitch filter / debouncer with a shared sample-tick prescaler.
// Define GLITCH_FILTER_SYNC_EN to add a 2-flop synchroniser on every input.
module glitch_filter_mc
  import glitch_filter_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter bit RESET_VAL = DEF_RESET_VAL
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int PCNT_WIDTH = clog2(PRESCALE);
  localparam logic [PCNT_WIDTH-1:0] PCNT_LAST = PCNT_WIDTH'(PRESCALE - 1);

  logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                  tick;

  // With PRESCALE=1 the counter sits at zero and tick simply follows enable.
  assign tick = enable && (pcnt_q == PCNT_LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    if (enable) begin
      pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gChan
    glitch_filter_chan #(
      .DEPTH    (DEPTH),
      .RESET_VAL(RESET_VAL)
    ) uChan (
      .clock (clock),
      .reset (reset),
      .tick_i(tick),
      .sig_i (sig_in[g]),
      .sig_o (sig_out[g]),
      .rise_o(rise[g]),
      .fall_o(fall[g])
    );
  end

endmodule

// File: tb/tb_glitch_filter_mc.sv
// Randomised bench for glitch_filter_mc: two instances (fast/reset-low and
// prescaled/reset-high) compared every cycle against a sample-history model.
module tb_glitch_filter_mc;

  localparam int DEPTH = 3;
`ifdef GLITCH_FILTER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clock  = 1'b0;
  bit         clkRun = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] sigIn  = 4'hF;

  logic [3:0] outA, riseA, fallA;
  logic [3:0] outB, riseB, fallB;

  int checks   = 0;
  int failures = 0;

  always begin
    #5;
    if (clkRun) clock = ~clock;
  end

  glitch_filter_mc #(
    .CHANNELS(4), .DEPTH(DEPTH), .PRESCALE(1), .RESET_VAL(1'b0)
  ) dutA (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sigIn),
    .sig_out(outA), .rise(riseA), .fall(fallA)
  );

  glitch_filter_mc #(
    .CHANNELS(4), .DEPTH(DEPTH), .PRESCALE(4), .RESET_VAL(1'b1)
  ) dutB (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sigIn),
    .sig_out(outB), .rise(riseB), .fall(fallB)
  );

  // Reference model: per instance, the history of sampled values on ticks.
  int         presc[2];
  logic [3:0] rv[2];
  logic [3:0] mOut[2], mRise[2], mFall[2];
  logic [3:0] sy1[2], sy2[2];
  int         enCnt[2];
  bit   [7:0] hist[2][4];
  int         nTick[2][4];

  task automatic modelReset();
    presc[0] = 1;    presc[1] = 4;
    rv[0]    = 4'h0; rv[1]    = 4'hF;
    for (int d = 0; d < 2; d++) begin
      mOut[d]  = rv[d];
      mRise[d] = 4'h0;
      mFall[d] = 4'h0;
      sy1[d]   = rv[d];
      sy2[d]   = rv[d];
      enCnt[d] = 0;
      for (int c = 0; c < 4; c++) begin
        hist[d][c]  = 8'h0;
        nTick[d][c] = 0;
      end
    end
  endtask

  // A flip happens when the last DEPTH ticked samples all differ from the output.
  task automatic modelEdge(input logic en, input logic [3:0] in);
    logic [3:0] s;
    bit         allDiff;
    for (int d = 0; d < 2; d++) begin
      s = (SYNC_LAT != 0) ? sy2[d] : in;
      sy2[d]   = sy1[d];
      sy1[d]   = in;
      mRise[d] = 4'h0;
      mFall[d] = 4'h0;
      if (en) begin
        enCnt[d]++;
        if (enCnt[d] % presc[d] == 0) begin
          for (int c = 0; c < 4; c++) begin
            hist[d][c] = {hist[d][c][6:0], s[c]};
            nTick[d][c]++;
            allDiff = (nTick[d][c] >= DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
              if (hist[d][c][i] == mOut[d][c]) allDiff = 1'b0;
            end
            if (allDiff) begin
              mOut[d][c] = ~mOut[d][c];
              if (mOut[d][c]) mRise[d][c] = 1'b1;
              else            mFall[d][c] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("A.sig_out", 32'(outA),  32'(mOut[0]));
    checkOutput("A.rise",    32'(riseA), 32'(mRise[0]));
    checkOutput("A.fall",    32'(fallA), 32'(mFall[0]));
    checkOutput("B.sig_out", 32'(outB),  32'(mOut[1]));
    checkOutput("B.rise",    32'(riseB), 32'(mRise[1]));
    checkOutput("B.fall",    32'(fallB), 32'(mFall[1]));
  endtask

  // Drive one cycle of inputs, then check just after the edge that consumes them.
  task automatic applyStimulus(input logic en, input logic [3:0] in);
    enable = en;
    sigIn  = in;
    @(posedge clock);
    modelEdge(en, in);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    compareAll();
    #1;
    reset = 1'b1;
  endtask

  // Counts edges until channel ch of instance A reaches level; returns 99 on timeout.
  task automatic measureA(input int ch, input logic [3:0] in, output int lat);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, in);
      if (outA[ch] == in[ch]) begin
        lat = i;
        break;
      end
    end
  endtask

  logic [3:0] glitchSeq [8];
  logic [3:0] cur;
  int         lat;

  initial begin
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    compareAll();
    #1;
    reset  = 1'b1;
    clkRun = 1'b1;

    repeat (8) applyStimulus(1'b1, 4'h0);

    measureA(0, 4'h1, lat);
    checkOutput("A.step_latency", 32'(lat), 32'(DEPTH + SYNC_LAT));
    repeat (4) applyStimulus(1'b1, 4'h1);

    glitchSeq = '{4'h3, 4'h3, 4'h1, 4'h3, 4'h1, 4'h3, 4'h3, 4'h3};
    foreach (glitchSeq[i]) applyStimulus(1'b1, glitchSeq[i]);
    repeat (6) applyStimulus(1'b1, 4'h3);

    repeat (16) applyStimulus(1'b1, 4'h7);
    repeat (30) applyStimulus(1'b1, 4'hF);

    repeat (8) applyStimulus(1'b1, 4'h7);
    repeat (5) applyStimulus(1'b0, 4'h7);
    repeat (12) applyStimulus(1'b1, 4'h7);

    repeat (8) applyStimulus(1'b1, 4'h0);
    repeat (2) applyStimulus(1'b1, 4'h8);
    doReset();
    measureA(3, 4'h8, lat);
    checkOutput("A.reset_mid_latency", 32'(lat), 32'(DEPTH + SYNC_LAT));

    cur = 4'h0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 3) == 0) cur[c] = ~cur[c];
      end
      if ($urandom_range(0, 149) == 0) doReset();
      applyStimulus(($urandom_range(0, 9) != 0), cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
